// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper sequencer.
// Optional build macro STEPPER_POS_EN adds a signed position output to stepper_seq.
package stepper_pkg;

    // Sequencer control states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Position within the 8-entry half-step table
    typedef logic [2:0] index_t;

    // Coil pattern per index, packed as {en_a, phase_a, en_b, phase_b}.
    // The first element in the concatenation is index 7 and the last is index 0.
    localparam logic [7:0][3:0] STEP_TABLE = {
        4'b1100,  // 7
        4'b1110,  // 6
        4'b0010,  // 5
        4'b1010,  // 4
        4'b1000,  // 3
        4'b1011,  // 2
        4'b0011,  // 1
        4'b1111   // 0
    };

    // Shortest step period accepted; smaller requests are raised to this
    localparam int PERIOD_MIN = 2;

    // Coil pattern lookup for one table index
    function automatic logic [3:0] step_pattern(input index_t idx);
        return STEP_TABLE[idx];
    endfunction

endpackage

// File: rtl/stepper_pwm.sv
// Free-running PWM generator for the driver VREF current reference.
// vref is high while the counter is below the duty value, so duty 0 gives constant low.
module stepper_pwm
    import stepper_pkg::*;
#(
    parameter int PWM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] duty,
    output logic             vref
);

    logic [PWM_W-1:0] pwm_cnt;

    // Counter wraps naturally; the compare result is registered to keep vref glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            vref    <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values, whatever the statement order.
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            vref    <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/stepper_seq.sv
// Command-driven stepper sequencer for a two-coil driver channel.
// Accepts move commands on a valid/ready handshake, steps through the
// full- or half-step table at the commanded period, and drives the coil
// phase/enable pins plus a run/hold VREF PWM.
// Optional build macro STEPPER_POS_EN adds the signed position output.
module stepper_seq
    import stepper_pkg::*;
#(
    parameter int STEP_W   = 16,
    parameter int PERIOD_W = 24,
    parameter int PWM_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_dir,
    input  logic                     cmd_half,
    input  logic [STEP_W-1:0]        cmd_steps,
    input  logic [PERIOD_W-1:0]      cmd_period,
    input  logic                     abort,
    input  logic [PWM_W-1:0]         run_duty,
    input  logic [PWM_W-1:0]         hold_duty,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic                     phase_a,
    output logic                     phase_b,
    output logic                     en_a,
    output logic                     en_b,
    output logic                     standby,
`ifdef STEPPER_POS_EN
    output logic signed [STEP_W+7:0] position,
`endif
    output logic                     vref
);

`ifdef STEPPER_POS_EN
    localparam int POS_W = STEP_W + 8;
`endif

    // Control state
    state_t state, state_n;

    // Move datapath
    index_t              index, index_n;
    logic [PERIOD_W-1:0] cnt, cnt_n;
    logic [STEP_W-1:0]   rem, rem_n;
    logic [PERIOD_W-1:0] period_q, period_n;
    logic                dir_q, dir_n;
    logic                half_q, half_n;
    logic                energised, energised_n;
    logic                done_n, aborted_n;

`ifdef STEPPER_POS_EN
    logic signed [POS_W-1:0] pos_n;
`endif

    // Helpers derived from current state
    logic   accept;
    logic   terminal;
    logic   last_step;
    index_t stride;
    logic [PWM_W-1:0] duty;

    assign accept    = cmd_valid && cmd_ready;
    assign terminal  = (cnt == period_q - PERIOD_W'(1));
    assign last_step = terminal && (rem == STEP_W'(1));
    assign stride    = half_q ? 3'd1 : 3'd2;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_n     = state;
        index_n     = index;
        cnt_n       = cnt;
        rem_n       = rem;
        period_n    = period_q;
        dir_n       = dir_q;
        half_n      = half_q;
        energised_n = energised;
        done_n      = 1'b0;
        aborted_n   = 1'b0;
`ifdef STEPPER_POS_EN
        pos_n       = position;
`endif

        case (state)
            IDLE: begin
                if (accept) begin
                    energised_n = 1'b1;
                    dir_n       = cmd_dir;
                    half_n      = cmd_half;
                    period_n    = (cmd_period < PERIOD_W'(PERIOD_MIN)) ?
                                  PERIOD_W'(PERIOD_MIN) : cmd_period;
                    cnt_n       = '0;
                    rem_n       = cmd_steps;
                    if (cmd_steps == '0) begin
                        // Zero-length move completes immediately without motion
                        done_n = 1'b1;
                    end else begin
                        state_n = RUN;
                        // Full-step needs an even index; snapping is not a counted step
                        if (!cmd_half && index[0]) begin
                            index_n = index & 3'b110;
`ifdef STEPPER_POS_EN
                            pos_n   = position - POS_W'(1);
`endif
                        end
                    end
                end
            end

            RUN: begin
                if (terminal && (last_step || !abort)) begin
                    // A step due on the same cycle as abort still wins if it is the final one
                    index_n = dir_q ? index + stride : index - stride;
                    rem_n   = rem - STEP_W'(1);
                    cnt_n   = '0;
`ifdef STEPPER_POS_EN
                    pos_n   = dir_q ? position + POS_W'(stride) : position - POS_W'(stride);
`endif
                    if (last_step) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else if (abort) begin
                    state_n   = IDLE;
                    done_n    = 1'b1;
                    aborted_n = 1'b1;
                end else begin
                    cnt_n = cnt + PERIOD_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index     <= '0;
            cnt       <= '0;
            rem       <= '0;
            period_q  <= PERIOD_W'(PERIOD_MIN);
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            energised <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            en_a      <= 1'b0;
            phase_a   <= 1'b0;
            en_b      <= 1'b0;
            phase_b   <= 1'b0;
            standby   <= 1'b0;
`ifdef STEPPER_POS_EN
            position  <= '0;
`endif
        end else begin
            index     <= index_n;
            cnt       <= cnt_n;
            rem       <= rem_n;
            period_q  <= period_n;
            dir_q     <= dir_n;
            half_q    <= half_n;
            energised <= energised_n;
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n == RUN);
            done      <= done_n;
            aborted   <= aborted_n;
            {en_a, phase_a, en_b, phase_b} <= energised_n ? step_pattern(index_n) : 4'b0000;
            standby   <= 1'b1;
`ifdef STEPPER_POS_EN
            position  <= pos_n;
`endif
        end
    end

    // Run current while moving, hold current once energised, nothing before the first command
    always_comb begin
        duty = '0;
        if (state == RUN) begin
            duty = run_duty;
        end else if (energised) begin
            duty = hold_duty;
        end
    end

    stepper_pwm #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty),
        .vref  (vref)
    );

endmodule

// File: tb/tb_stepper_seq.sv
// Directed self-checking bench for stepper_seq.
// Define STEPPER_POS_EN to also check the position output.
module tb_stepper_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic        cmd_half;
    logic [15:0] cmd_steps;
    logic [23:0] cmd_period;
    logic        abort;
    logic [3:0]  run_duty;
    logic [3:0]  hold_duty;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        phase_a;
    logic        phase_b;
    logic        en_a;
    logic        en_b;
    logic        standby;
    logic        vref;
`ifdef STEPPER_POS_EN
    logic signed [23:0] position;
`endif

    int vectors;
    int miscompares;
    int highs;
    int dones;

    stepper_seq #(
        .STEP_W   (16),
        .PERIOD_W (24),
        .PWM_W    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_half   (cmd_half),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .run_duty   (run_duty),
        .hold_duty  (hold_duty),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .phase_a    (phase_a),
        .phase_b    (phase_b),
        .en_a       (en_a),
        .en_b       (en_b),
        .standby    (standby),
`ifdef STEPPER_POS_EN
        .position   (position),
`endif
        .vref       (vref)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-written coil table {en_a, phase_a, en_b, phase_b}
    function automatic logic [31:0] exp_pat(input int i);
        case (i & 7)
            0: return 32'b1111;
            1: return 32'b0011;
            2: return 32'b1011;
            3: return 32'b1000;
            4: return 32'b1010;
            5: return 32'b0010;
            6: return 32'b1110;
            default: return 32'b1100;
        endcase
    endfunction

    function automatic logic [31:0] pins();
        return {28'd0, en_a, phase_a, en_b, phase_b};
    endfunction

    task automatic send(input logic dir, input logic half, input int steps, input int period);
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_half   = half;
        cmd_steps  = 16'(steps);
        cmd_period = 24'(period);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_dir     = 1'b0;
        cmd_half    = 1'b0;
        cmd_steps   = '0;
        cmd_period  = '0;
        abort       = 1'b0;
        run_duty    = 4'd3;
        hold_duty   = 4'd1;

        // ---- reset state ----
        tick();
        tick();
        check("rst cmd_ready", 32'(cmd_ready), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst standby", 32'(standby), 0);
        check("rst pins", pins(), 0);
        check("rst vref", 32'(vref), 0);
        rst_n = 1'b1;
        tick();
        check("post-rst cmd_ready", 32'(cmd_ready), 1);
        check("post-rst standby", 32'(standby), 1);
        check("post-rst busy", 32'(busy), 0);
        check("post-rst pins", pins(), 0);

        // ---- vref stays low before any command ----
        highs = 0;
        for (int c = 0; c < 20; c++) begin
            highs += int'(vref);
            tick();
        end
        check("vref before first cmd", 32'(highs), 0);

        // ---- full-step forward, 4 steps, period 10 ----
        send(1'b1, 1'b0, 4, 10);
        tick();
        cmd_valid = 1'b0;
        highs = 0;
        for (int c = 1; c <= 42; c++) begin
            check($sformatf("t1 pins c%0d", c), pins(), exp_pat(((c - 1) / 10) * 2));
            check($sformatf("t1 busy c%0d", c), 32'(busy), (c <= 40) ? 1 : 0);
            check($sformatf("t1 ready c%0d", c), 32'(cmd_ready), (c <= 40) ? 0 : 1);
            check($sformatf("t1 done c%0d", c), 32'(done), (c == 41) ? 1 : 0);
            if (c == 41) check("t1 aborted", 32'(aborted), 0);
            if (c >= 5 && c <= 20) highs += int'(vref);
            // A command offered mid-move must be ignored
            if (c >= 5 && c <= 8) send(1'b0, 1'b1, 7, 3);
            else cmd_valid = 1'b0;
            tick();
        end
        check("vref run 3/16", 32'(highs), 3);
        highs = 0;
        for (int c = 0; c < 16; c++) begin
            highs += int'(vref);
            tick();
        end
        check("vref hold 1/16", 32'(highs), 1);
`ifdef STEPPER_POS_EN
        check("t1 position", 32'(position), 8);
`endif

        // ---- half-step reverse, 3 steps, period 5, from index 0 ----
        send(1'b0, 1'b1, 3, 5);
        tick();
        cmd_valid = 1'b0;
        dones = 0;
        for (int c = 1; c <= 17; c++) begin
            check($sformatf("t2 pins c%0d", c), pins(),
                  exp_pat((c <= 5) ? 0 : (c <= 10) ? 7 : (c <= 15) ? 6 : 5));
            check($sformatf("t2 done c%0d", c), 32'(done), (c == 16) ? 1 : 0);
            if (c == 16) check("t2 en_a at idx5", 32'(en_a), 0);
            dones += int'(done);
            tick();
        end
        check("t2 done pulses", 32'(dones), 1);
`ifdef STEPPER_POS_EN
        check("t2 position", 32'(position), 5);
`endif

        // ---- full-step accepted at odd index 5: snap to 4, then step to 6 ----
        send(1'b1, 1'b0, 1, 4);
        tick();
        cmd_valid = 1'b0;
        check("t3 snapped pins", pins(), exp_pat(4));
`ifdef STEPPER_POS_EN
        check("t3 position after snap", 32'(position), 4);
`endif
        tick();
        tick();
        tick();
        check("t3 pins before step", pins(), exp_pat(4));
        tick();
        check("t3 pins after step", pins(), exp_pat(6));
        check("t3 done", 32'(done), 1);
`ifdef STEPPER_POS_EN
        check("t3 position after step", 32'(position), 6);
`endif
        tick();

        // ---- abort 3 cycles after accept, period 100 ----
        send(1'b1, 1'b0, 5, 100);
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("t4 busy c%0d", c), 32'(busy), 1);
            abort = (c == 3);
            tick();
        end
        abort = 1'b0;
        check("t4 done", 32'(done), 1);
        check("t4 aborted", 32'(aborted), 1);
        check("t4 busy", 32'(busy), 0);
        check("t4 ready", 32'(cmd_ready), 1);
        check("t4 pins held", pins(), exp_pat(6));

        // ---- steps = 0 accepted right after the abort ----
        send(1'b1, 1'b1, 0, 7);
        tick();
        cmd_valid = 1'b0;
        check("t5 done", 32'(done), 1);
        check("t5 aborted", 32'(aborted), 0);
        check("t5 busy", 32'(busy), 0);
        check("t5 pins", pins(), exp_pat(6));
        tick();
        check("t5 done clears", 32'(done), 0);

        // ---- abort while idle is ignored ----
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle abort done", 32'(done), 0);
        check("idle abort busy", 32'(busy), 0);
        tick();
        check("idle abort done later", 32'(done), 0);

        // ---- period 0 runs as 2; abort on the final terminal count still steps ----
        send(1'b1, 1'b1, 2, 0);
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("t6 pins c%0d", c), pins(),
                  exp_pat((c <= 2) ? 6 : (c <= 4) ? 7 : 0));
            check($sformatf("t6 done c%0d", c), 32'(done), (c == 5) ? 1 : 0);
            if (c == 5) begin
                check("t6 aborted", 32'(aborted), 0);
                check("t6 busy", 32'(busy), 0);
            end
            abort = (c == 4);
            tick();
        end
        abort = 1'b0;
`ifdef STEPPER_POS_EN
        check("t6 position", 32'(position), 8);
`endif

        // ---- reset mid-move discards the move ----
        send(1'b1, 1'b0, 3, 10);
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        check("t7 busy before rst", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t7 async pins", pins(), 0);
        check("t7 async busy", 32'(busy), 0);
        check("t7 async standby", 32'(standby), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t7 ready", 32'(cmd_ready), 1);
        check("t7 pins", pins(), 0);
`ifdef STEPPER_POS_EN
        check("t7 position", 32'(position), 0);
`endif
        dones = 0;
        highs = 0;
        for (int c = 0; c < 40; c++) begin
            dones += int'(done);
            highs += int'(vref);
            tick();
        end
        check("t7 no done", 32'(dones), 0);
        check("t7 vref off", 32'(highs), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stepper_seq.md
Name: stepper_seq

Overview:
Command-driven stepper sequencer for the motor driver board. It accepts move commands on a valid/ready handshake, each carrying direction, step count and step period. It supports full-step and half-step sequencing and generates the phase/enable pattern for a two-coil driver channel. A PWM VREF output gives separate run and hold current levels. It replaces the fixed-rate free-running rotator and sits between the command logic (I2C/host) and the driver pins.

Parameters:
STEP_W, 16, width of step count in a command
PERIOD_W, 24, width of step period in clk cycles
PWM_W, 4, width of VREF PWM counter and duty inputs

Ports:
clk  in  1  system clock (27 MHz board clock)
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command
cmd_dir  in  1  1 = forward (index increments), 0 = reverse
cmd_half  in  1  1 = half-step, 0 = full-step
cmd_steps  in  STEP_W  number of steps to move
cmd_period  in  PERIOD_W  clk cycles per step
abort  in  1  stop current move
run_duty  in  PWM_W  VREF duty while moving
hold_duty  in  PWM_W  VREF duty while idle and energised
busy  out  1  move in progress
done  out  1  one-cycle pulse at move end
aborted  out  1  qualifies done; move ended by abort
phase_a, phase_b  out  1 each  coil polarity
en_a, en_b  out  1 each  coil enable (drive both INx1/INx2 from it)
standby  out  1  driver standby release
vref  out  1  PWM current reference

Behaviour:
- Reset: all outputs registered and 0. Index = 0, state IDLE, coils de-energised. cmd_ready rises on the first clk after rst_n deasserts. Reset mid-move discards the move with no done pulse.
- Step table, 3-bit index → (en_a,phase_a,en_b,phase_b): 0:1111, 1:0011, 2:1011, 3:1000, 4:1010, 5:0010, 6:1110, 7:1100. Full step uses even indices only; 0,2,4,6 gives the 11,01,00,10 phase sequence.
- States: IDLE, RUN. cmd_ready = (state==IDLE). busy = (state==RUN).
- Accept: cmd_valid && cmd_ready. dir, half, steps and period are latched.
  - period < 2 is clamped to 2.
  - Full-step with an odd index: index is snapped to index & 3'b110 at accept. This is not counted as a step.
  - The first accepted command energises the coils; they stay energised until reset.
- steps == 0: no motion, state stays IDLE, done=1 on the next cycle with aborted=0.
- RUN: the period counter runs 0..period-1. At terminal count the index changes by ±1 (half) or ±2 (full), mod 8 wrap, and remaining steps decrement. The first step occurs period cycles after accept. Outputs update one cycle after terminal count.
- When the final step is issued, the next cycle gives state→IDLE, done=1, aborted=0.
- abort in RUN: the next cycle gives state→IDLE, done=1, aborted=1, and the index holds its current value. If abort and the final terminal count occur in the same cycle, the step is taken and aborted=0. abort in IDLE is ignored.
- Command inputs are ignored while in RUN, because cmd_ready=0.
- VREF: a free-running PWM_W counter c. Duty d = run_duty in RUN, hold_duty in IDLE energised, 0 if never energised. vref <= (c < d). d=0 gives constant 0. Duty inputs are sampled every cycle.
- standby: 0 in reset, 1 afterwards.

Optional Feature:
STEPPER_POS_EN: adds output position (signed, STEP_W+8 bits), reset 0.
- Counts +1 per half-step forward and −1 per half-step reverse; a full step counts ±2.
- The snap at accept counts −1.
- Wraps two's-complement.
Without the macro the port and its logic are absent and all other behaviour is identical.

Decomposition:
Package stepper_pkg:
- state enum (IDLE, RUN)
- index type logic[2:0]
- localparam step table (8×4 bits)
- period clamp minimum constant (2)
Sub-module stepper_pwm holds the PWM counter and compare (PWM_W, duty in, vref out). All other logic stays in stepper_seq.

Test Plan:
- Reset, then a full-step command with dir=1, steps=4, period=10 → index 0→2→4→6→0 at cycles 10, 20, 30, 40 after accept; done pulse at 41; cmd_ready low for exactly that span.
- Half-step command with dir=0, steps=3, period=5 from index 0 → indices 7, 6, 5; en_a=0 at index 5; one done pulse.
- Full-step command accepted at index 5 → snapped to 4, then steps to 6; with STEPPER_POS_EN, position changes −1 then +2.
- abort asserted 3 cycles after accept (period=100) → done=1 and aborted=1 one cycle later; index unchanged; a new command is accepted on the next valid.
- Edge cases: steps=0 gives done the next cycle with no index change; period=0 behaves as period=2; abort coinciding with the final step gives aborted=0.
- PWM check with PWM_W=4, run_duty=3, hold_duty=1 → vref high 3/16 of cycles in RUN and 1/16 in IDLE; vref stays 0 before the first command.
